// File: rtl/kb_pkg.sv
// Shared types for the keyboard command path: command opcodes, scheduler
// states, input-vector bit positions and encoder key codes.
package kb_pkg;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_INSERT = 3'd1,
        OP_DELETE = 3'd2,
        OP_LEFT   = 3'd3,
        OP_RIGHT  = 3'd4,
        OP_EVAL   = 3'd5
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_ISSUE,
        ST_WAIT_RELEASE
    } sched_state_e;

    // Bit positions inside v = {eval, del, left, right, insert}
    localparam int unsigned KV_INSERT = 0;
    localparam int unsigned KV_RIGHT  = 1;
    localparam int unsigned KV_LEFT   = 2;
    localparam int unsigned KV_DEL    = 3;
    localparam int unsigned KV_EVAL   = 4;

    localparam logic [7:0] KEY_0      = 8'h00;
    localparam logic [7:0] KEY_1      = 8'h01;
    localparam logic [7:0] KEY_2      = 8'h02;
    localparam logic [7:0] KEY_3      = 8'h03;
    localparam logic [7:0] KEY_4      = 8'h04;
    localparam logic [7:0] KEY_5      = 8'h05;
    localparam logic [7:0] KEY_6      = 8'h06;
    localparam logic [7:0] KEY_7      = 8'h07;
    localparam logic [7:0] KEY_8      = 8'h08;
    localparam logic [7:0] KEY_9      = 8'h09;
    localparam logic [7:0] KEY_LPAREN = 8'h28;
    localparam logic [7:0] KEY_RPAREN = 8'h29;
    localparam logic [7:0] KEY_MUL    = 8'h2A;
    localparam logic [7:0] KEY_ADD    = 8'h2B;
    localparam logic [7:0] KEY_COMMA  = 8'h2C;
    localparam logic [7:0] KEY_SUB    = 8'h2D;
    localparam logic [7:0] KEY_DOT    = 8'h2E;
    localparam logic [7:0] KEY_DIV    = 8'h2F;
    localparam logic [7:0] KEY_E      = 8'h45;
    localparam logic [7:0] KEY_PI     = 8'h50;
    localparam logic [7:0] KEY_SIN    = 8'h60;
    localparam logic [7:0] KEY_COS    = 8'h61;
    localparam logic [7:0] KEY_TAN    = 8'h62;
    localparam logic [7:0] KEY_LN     = 8'h63;
    localparam logic [7:0] KEY_SQRT   = 8'h64;

    function automatic cmd_op_e prio_op(input logic [4:0] v);
        if (v[KV_EVAL])        return OP_EVAL;
        else if (v[KV_DEL])    return OP_DELETE;
        else if (v[KV_LEFT])   return OP_LEFT;
        else if (v[KV_RIGHT])  return OP_RIGHT;
        else if (v[KV_INSERT]) return OP_INSERT;
        else                   return OP_NONE;
    endfunction

    function automatic logic op_repeats(input cmd_op_e op);
        return (op == OP_DELETE) || (op == OP_LEFT) || (op == OP_RIGHT);
    endfunction

endpackage

// File: rtl/kb_debounce_cnt.sv
// Loadable up-counter that saturates at a run-time terminal value; tc is high
// once the count has reached the terminal.
module kb_debounce_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;

    assign tc = (count_q >= term);

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (inc && !tc) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/kb_cmd_scheduler.sv
// Debounces encoder key levels and issues one prioritised command per press
// over valid/ready. Optional auto-repeat of DELETE/LEFT/RIGHT: KB_AUTOREPEAT_EN.
module kb_cmd_scheduler
    import kb_pkg::*;
#(
    parameter int width           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_insert,
    input  logic [width-1:0] key_data,
    input  logic             key_del,
    input  logic             key_left,
    input  logic             key_right,
    input  logic             key_eval,
    input  logic             eval_busy,
    input  logic             cmd_ready,
    output logic             cmd_valid,
    output logic [2:0]       cmd_op,
    output logic [width-1:0] cmd_data,
    output logic             busy
);

    localparam longint CNT_MAX = longint'((64'd1 << CNT_W) - 64'd1);

    if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES - 1) > CNT_MAX ||
        longint'(REPEAT_DELAY - 1) > CNT_MAX || longint'(REPEAT_PERIOD - 1) > CNT_MAX ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || width < 1) begin : g_bad_params
        $error("kb_cmd_scheduler: parameter out of range");
    end

    logic [4:0]       v;
    sched_state_e     state_q, state_d;
    logic [4:0]       snap_v_q;
    logic [width-1:0] snap_data_q;
    cmd_op_e          snap_op;
    logic             snap_we, changed;
    logic             deb_load, deb_inc, deb_tc;
    logic             rep_fire;
    logic             cmd_valid_q, busy_q;
    cmd_op_e          cmd_op_q;
    logic [width-1:0] cmd_data_q;

    assign v       = {key_eval, key_del, key_left, key_right, key_insert};
    assign snap_op = prio_op(snap_v_q);
    assign changed = (v != snap_v_q) || (snap_v_q[KV_INSERT] && (key_data != snap_data_q));

    kb_debounce_cnt #(.CNT_W(CNT_W)) u_deb_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (deb_load),
        .load_val ('0),
        .inc      (deb_inc),
        .term     (CNT_W'(DEBOUNCE_CYCLES - 1)),
        .tc       (deb_tc)
    );

`ifdef KB_AUTOREPEAT_EN
    logic             rep_armed_q, rep_mode_q, rep_hold, rep_load, rep_inc, rep_tc;
    logic [CNT_W-1:0] rep_load_val, rep_term;

    // First repeat counts REPEAT_DELAY held cycles after the handshake; later
    // ones count the handshake cycle itself, so they start from 1.
    assign rep_hold     = (state_q == ST_WAIT_RELEASE) && rep_armed_q && (v == snap_v_q) && !eval_busy;
    assign rep_fire     = rep_hold && rep_tc;
    assign rep_inc      = rep_hold && !rep_tc;
    assign rep_load     = (state_q == ST_ISSUE) && cmd_ready;
    assign rep_load_val = rep_mode_q ? CNT_W'(1) : '0;
    assign rep_term     = rep_mode_q ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1);

    kb_debounce_cnt #(.CNT_W(CNT_W)) u_rep_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (rep_load),
        .load_val (rep_load_val),
        .inc      (rep_inc),
        .term     (rep_term),
        .tc       (rep_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            rep_armed_q <= 1'b0;
            rep_mode_q  <= 1'b0;
        end else begin
            if (state_q == ST_ISSUE && cmd_ready)
                rep_armed_q <= op_repeats(snap_op);
            else if (state_q == ST_WAIT_RELEASE && (v != snap_v_q || eval_busy))
                rep_armed_q <= 1'b0;
            if (state_q == ST_DEBOUNCE)
                rep_mode_q <= 1'b0;
            else if (rep_fire)
                rep_mode_q <= 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        snap_we  = 1'b0;
        deb_load = 1'b0;
        deb_inc  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (v != '0 && !eval_busy) begin
                    snap_we  = 1'b1;
                    deb_load = 1'b1;
                    state_d  = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (eval_busy) begin
                    deb_load = 1'b1;
                    state_d  = ST_WAIT_RELEASE;
                end else if (changed) begin
                    state_d = ST_IDLE;
                end else if (deb_tc) begin
                    state_d = ST_ISSUE;
                end else begin
                    deb_inc = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    deb_load = 1'b1;
                    state_d  = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (rep_fire) begin
                    state_d = ST_ISSUE;
                end else if (v != '0) begin
                    deb_load = 1'b1;
                end else if (deb_tc) begin
                    state_d = ST_IDLE;
                end else begin
                    deb_inc = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            snap_v_q    <= '0;
            snap_data_q <= '0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= OP_NONE;
            cmd_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (snap_we) begin
                snap_v_q    <= v;
                snap_data_q <= key_data;
            end
            cmd_valid_q <= (state_d == ST_ISSUE);
            cmd_op_q    <= (state_d == ST_ISSUE) ? snap_op : OP_NONE;
            cmd_data_q  <= (state_d == ST_ISSUE && snap_op == OP_INSERT) ? snap_data_q : '0;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_op_q;
    assign cmd_data  = cmd_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_kb_cmd_scheduler.sv
// Directed and randomized checks of kb_cmd_scheduler against press-level
// expectations (latency, priority, one command per press, lockout, reset).
module tb_kb_cmd_scheduler;
    import kb_pkg::*;

    localparam int W  = 8;
    localparam int DC = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic         clock = 1'b0;
    logic         reset, key_insert, key_del, key_left, key_right, key_eval;
    logic         eval_busy, cmd_ready, cmd_valid, busy;
    logic [W-1:0] key_data, cmd_data;
    logic [2:0]   cmd_op;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    always #5 clock = ~clock;

    kb_cmd_scheduler #(
        .width(W), .DEBOUNCE_CYCLES(DC), .CNT_W(16), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clock(clock), .reset(reset), .key_insert(key_insert), .key_data(key_data),
        .key_del(key_del), .key_left(key_left), .key_right(key_right), .key_eval(key_eval),
        .eval_busy(eval_busy), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .busy(busy)
    );

    // Accepted commands and cycle stamps, relative to c0 of the current step
    logic [2:0]   acc_op[$];
    logic [W-1:0] acc_data[$];
    int           acc_cyc[$];
    int           rise_cyc[$];
    int           cyc = 0, c0 = 0, n_valid_hi = 0;
    logic         prev_valid = 1'b0, rand_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        if (rand_ready) cmd_ready = ($urandom_range(0, 3) != 0);
        if (cmd_valid && cmd_ready) begin
            acc_op.push_back(cmd_op);
            acc_data.push_back(cmd_data);
            acc_cyc.push_back(cyc - c0);
        end
        @(posedge clock);
        #1;
        cyc++;
        if (cmd_valid && !prev_valid) rise_cyc.push_back(cyc - c0);
        if (cmd_valid) n_valid_hi++;
        prev_valid = cmd_valid;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start();
        acc_op.delete(); acc_data.delete(); acc_cyc.delete(); rise_cyc.delete();
        n_valid_hi = 0;
        c0 = cyc;
    endtask

    task automatic set_keys(input logic [4:0] kv, input logic [W-1:0] d);
        {key_eval, key_del, key_left, key_right, key_insert} = kv;
        key_data = d;
    endtask

    function automatic logic [2:0] ref_op(input logic [4:0] kv);
        if (kv[4]) return 3'd5;
        if (kv[3]) return 3'd2;
        if (kv[2]) return 3'd3;
        if (kv[1]) return 3'd4;
        if (kv[0]) return 3'd1;
        return 3'd0;
    endfunction

    task automatic expect_one(input string tag, input logic [2:0] op, input logic [W-1:0] d, input int at);
        check({tag, "_count"}, acc_op.size(), 1);
        if (acc_op.size() > 0) begin
            check({tag, "_op"}, acc_op[0], op);
            check({tag, "_data"}, acc_data[0], d);
            if (at >= 0) check({tag, "_cycle"}, acc_cyc[0], at);
        end
    endtask

    task automatic release_and_idle(input string tag);
        int n;
        set_keys('0, '0);
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; eval_busy = 1'b0; cmd_ready = 1'b1;
        set_keys('0, '0);
        run(2);
        check("rst_valid", cmd_valid, 1'b0);
        check("rst_op", cmd_op, 3'd0);
        check("rst_data", cmd_data, '0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        run(2);

        // Insert: first valid DC+1 cycles after the press, single cycle with ready high
        start();
        set_keys(5'b00001, 8'h07);
        run(20);
        expect_one("ins", 3'd1, 8'h07, DC + 1);
        check("ins_valid_cycles", n_valid_hi, 1);
        set_keys('0, '0);
        run(DC - 1);
        check("ins_busy_before", busy, 1'b1);
        step();
        check("ins_busy_after", busy, 1'b0);

        // Bounce: the debounce window restarts at the last transition
        start();
        set_keys(5'b01000, 8'h55); step();
        set_keys(5'b00000, 8'h55); step();
        set_keys(5'b01000, 8'h55);
        run(15);
        expect_one("bounce", 3'd2, 8'h00, 2 + DC + 1);
        release_and_idle("bounce");

        // Press held exactly DC cycles is one cycle short
        start();
        set_keys(5'b00010, 8'h00);
        run(DC);
        release_and_idle("short");
        check("short_none", acc_op.size(), 0);

        // Backpressure: command held stable until accepted
        start();
        cmd_ready = 1'b0;
        set_keys(5'b10000, 8'h00);
        run(DC + 1);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", cmd_valid, 1'b1);
            check("bp_op", cmd_op, 3'd5);
            step();
        end
        cmd_ready = 1'b1;
        step();
        check("bp_drop", cmd_valid, 1'b0);
        expect_one("bp", 3'd5, 8'h00, DC + 11);
        release_and_idle("bp");

        // Priority: LEFT beats INSERT, nothing further while held
        start();
        set_keys(5'b00101, KEY_MUL);
        run(15);
        expect_one("prio", 3'd3, 8'h00, DC + 1);
        release_and_idle("prio");

        // Lockout during debounce: press discarded, busy until release debounced
        start();
        set_keys(5'b00010, 8'h00);
        run(2);
        eval_busy = 1'b1; step(); eval_busy = 1'b0;
        run(20);
        check("lock_none", acc_op.size(), 0);
        check("lock_busy", busy, 1'b1);
        set_keys('0, '0);
        run(DC - 1);
        check("lock_busy_before", busy, 1'b1);
        step();
        check("lock_busy_after", busy, 1'b0);

        // Key held while evaluator busy in IDLE is picked up once busy falls
        start();
        eval_busy = 1'b1;
        set_keys(5'b00001, 8'h31);
        run(10);
        check("idle_lock_busy", busy, 1'b0);
        check("idle_lock_none", acc_op.size(), 0);
        eval_busy = 1'b0;
        start();
        run(DC + 4);
        expect_one("idle_lock", 3'd1, 8'h31, DC + 1);
        release_and_idle("idle_lock");

        // Reset while a command is pending
        start();
        cmd_ready = 1'b0;
        set_keys(5'b01000, 8'h00);
        run(DC + 3);
        check("rmid_valid", cmd_valid, 1'b1);
        reset = 1'b1;
        set_keys('0, '0);
        step();
        check("rmid_valid0", cmd_valid, 1'b0);
        check("rmid_op0", cmd_op, 3'd0);
        check("rmid_busy0", busy, 1'b0);
        reset = 1'b0;
        cmd_ready = 1'b1;
        run(3);
        check("rmid_none", acc_op.size(), 0);

`ifdef KB_AUTOREPEAT_EN
        start();
        set_keys(5'b01000, 8'h00);
        run(50);
        release_and_idle("rep");
        check("rep_count", acc_op.size(), 5);
        for (int i = 0; i < 5; i++) begin
            int exp_at[5] = '{5, 26, 34, 42, 50};
            if (i < acc_op.size()) begin
                check("rep_op", acc_op[i], 3'd2);
                check("rep_cycle", acc_cyc[i], exp_at[i]);
            end
        end
`endif

        // Random presses with random backpressure
        rand_ready = 1'b1;
        for (int ep = 0; ep < 40; ep++) begin
            logic [4:0]   kv;
            logic [W-1:0] d;
            int           h;
            kv = 5'($urandom_range(1, 31));
            d  = W'($urandom);
            h  = $urandom_range(1, 9);
            start();
            set_keys(kv, d);
            run(h);
            release_and_idle("rnd");
            if (h >= DC + 1) begin
                expect_one("rnd", ref_op(kv), (ref_op(kv) == 3'd1) ? d : '0, -1);
                check("rnd_rise_count", rise_cyc.size(), 1);
                if (rise_cyc.size() > 0) check("rnd_latency", rise_cyc[0], DC + 1);
            end else begin
                check("rnd_none", acc_op.size(), 0);
            end
        end
        rand_ready = 1'b0;
        cmd_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
